// File: rtl/mips_mmio_pkg.sv
// Shared constants for the MIPS data-memory subsystem: MMIO window,
// register offsets, STAT bit positions and the CMP reset value.
package mips_mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  // Byte offsets of the MMIO registers inside the window.
  localparam logic [3:0] OFS_CNT  = 4'h0;
  localparam logic [3:0] OFS_CMP  = 4'h4;
  localparam logic [3:0] OFS_STAT = 4'h8;
  localparam logic [3:0] OFS_LED  = 4'hC;

  // Word index of each register, i.e. address bits [3:2].
  typedef enum logic [1:0] {
    REG_CNT  = 2'd0,
    REG_CMP  = 2'd1,
    REG_STAT = 2'd2,
    REG_LED  = 2'd3
  } mmio_reg_e;

  localparam int STAT_MATCH_BIT = 0;
  localparam int STAT_IEN_BIT   = 1;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

  // Bit 31 alone splits the space: low half RAM, high half MMIO.
  function automatic logic is_mmio(input logic [31:0] addr);
    return addr[31] == MMIO_BASE[31];
  endfunction

  // Register offset of an MMIO access; address bits [30:4] and [1:0] ignored.
  function automatic logic [3:0] reg_ofs(input logic [31:0] addr);
    return {addr[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word RAM: combinational read, synchronous write. Contents are not reset.
module dmem_ram #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];

  // Store on the rising edge when the top has selected the RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read is purely combinational, so a same-cycle store returns old data.
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory subsystem: word RAM in the low half of the address space,
// cycle counter / compare / status / LED registers in the high half.
module dmem_mmio
  import mips_mmio_pkg::*;
#(
  parameter int RAM_AW = 8,
  parameter int LED_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memwrite,
  input  logic [31:0]      aluout,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] leds,
  output logic             irq
);

  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      cmp_q, cmp_d;
  logic             flag_q, flag_d;
  logic             ien_q, ien_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             irq_q;

  logic        sel_mmio;
  logic [3:0]  ofs;
  logic        wr_cnt, wr_cmp, wr_stat, wr_led;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] stat_rd;
  logic        unused_addr_bits;

  assign sel_mmio = is_mmio(aluout);
  assign ofs      = reg_ofs(aluout);
  assign wr_cnt   = memwrite && sel_mmio && (ofs == OFS_CNT);
  assign wr_cmp   = memwrite && sel_mmio && (ofs == OFS_CMP);
  assign wr_stat  = memwrite && sel_mmio && (ofs == OFS_STAT);
  assign wr_led   = memwrite && sel_mmio && (ofs == OFS_LED);

  // A store that coincides with reset is dropped, RAM included.
  assign ram_we = memwrite && !sel_mmio && !rst;

  // Byte-lane bits and the MMIO don't-care bits are intentionally unused.
  assign unused_addr_bits = ^{aluout[30:4], aluout[1:0]};

  dmem_ram #(.AW(RAM_AW)) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (aluout[RAM_AW+1:2]),
    .wdata_i (writedata),
    .rdata_o (ram_rdata)
  );

  // Next-state for the peripheral registers; the match uses pre-edge CNT/CMP.
  always_comb begin
    cnt_d  = wr_cnt ? writedata : cnt_q + 32'd1;
    cmp_d  = wr_cmp ? writedata : cmp_q;
    ien_d  = wr_stat ? writedata[STAT_IEN_BIT] : ien_q;
    led_d  = wr_led ? writedata[LED_W-1:0] : led_q;
    flag_d = flag_q;
    if (wr_stat && writedata[STAT_MATCH_BIT]) begin
      flag_d = 1'b0;
    end
    // Setting after the W1C makes a same-edge match win over the clear.
    if (cnt_q == cmp_q) begin
      flag_d = 1'b1;
    end
  end

  // Peripheral register bank with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      cmp_q  <= CMP_RST;
      flag_q <= 1'b0;
      ien_q  <= 1'b0;
      led_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      flag_q <= flag_d;
      ien_q  <= ien_d;
      led_q  <= led_d;
      irq_q  <= flag_d && ien_d;
    end
  end

  // Side-effect-free read mux over RAM and the four MMIO registers.
  always_comb begin
    stat_rd                 = '0;
    stat_rd[STAT_MATCH_BIT] = flag_q;
    stat_rd[STAT_IEN_BIT]   = ien_q;
    readdata                = ram_rdata;
    if (sel_mmio) begin
      case (mmio_reg_e'(aluout[3:2]))
        REG_CNT:  readdata = cnt_q;
        REG_CMP:  readdata = cmp_q;
        REG_STAT: readdata = stat_rd;
        REG_LED:  readdata = 32'(led_q);
        default:  readdata = '0;
      endcase
    end
  end

  assign leds = led_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: reference model of the memory map, vector table,
// directed multi-cycle sequences and a randomized phase.
module tb_dmem_mmio;

  localparam int RAM_AW = 8;
  localparam int LED_W  = 8;
  localparam int DEPTH  = 2**RAM_AW;

  logic             clk = 1'b0;
  logic             rst;
  logic             memwrite;
  logic [31:0]      aluout;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [LED_W-1:0] leds;
  logic             irq;

  int n_checks = 0;
  int n_errors = 0;

  dmem_mmio #(.RAM_AW(RAM_AW), .LED_W(LED_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .leds      (leds),
    .irq       (irq)
  );

  // Clock block
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: architectural state of the memory map.
  logic [31:0]      m_ram [DEPTH];
  bit               m_valid [DEPTH];
  logic [31:0]      m_cnt, m_cmp;
  logic             m_flag, m_ien, m_irq;
  logic [LED_W-1:0] m_led;

  task automatic model_reset();
    m_cnt  = 32'd0;
    m_cmp  = 32'hFFFF_FFFF;
    m_flag = 1'b0;
    m_ien  = 1'b0;
    m_irq  = 1'b0;
    m_led  = '0;
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] val,
                            output bit known);
    int idx;
    known = 1'b1;
    val   = 32'd0;
    if (addr[31]) begin
      case (addr[3:2])
        2'd0: val = m_cnt;
        2'd1: val = m_cmp;
        2'd2: val = {30'd0, m_ien, m_flag};
        default: val = {{(32-LED_W){1'b0}}, m_led};
      endcase
    end else begin
      idx   = int'((addr >> 2) % DEPTH);
      known = m_valid[idx];
      val   = m_ram[idx];
    end
  endtask

  task automatic model_edge(input logic we, input logic [31:0] addr,
                            input logic [31:0] data);
    bit          match;
    int          idx;
    logic [31:0] next_cnt;
    match    = (m_cnt == m_cmp);
    next_cnt = m_cnt + 32'd1;
    if (we && !addr[31]) begin
      idx          = int'((addr >> 2) % DEPTH);
      m_ram[idx]   = data;
      m_valid[idx] = 1'b1;
    end
    if (we && addr[31]) begin
      case (addr[3:2])
        2'd0: next_cnt = data;
        2'd1: m_cmp = data;
        2'd2: begin
          m_ien = data[1];
          if (data[0]) m_flag = 1'b0;
        end
        default: m_led = data[LED_W-1:0];
      endcase
    end
    if (match) m_flag = 1'b1;
    m_cnt = next_cnt;
    m_irq = m_flag && m_ien;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: one bus cycle, entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input bit chk,
                       input logic [31:0] exp, input string name);
    logic [31:0] mv;
    bit          known;
    memwrite  = we;
    aluout    = addr;
    writedata = data;
    #4;
    model_read(addr, mv, known);
    if (known) check({name, "/model_rd"}, readdata, mv);
    check({name, "/leds"}, 32'(leds), 32'(m_led));
    check({name, "/irq"}, 32'(irq), 32'(m_irq));
    if (chk) check(name, readdata, exp);
    @(posedge clk);
    model_edge(we, addr, data);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{1'b0, 32'h8000_0004, 32'h0,         1'b1, 32'hFFFF_FFFF};
    vecs[1]  = '{1'b0, 32'h8000_0008, 32'h0,         1'b1, 32'h0};
    vecs[2]  = '{1'b0, 32'h8000_000C, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 32'h0000_0410, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 32'h8000_0004, 32'h1234_5678, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h8000_1234, 32'h0,         1'b1, 32'h1234_5678};
    vecs[10] = '{1'b1, 32'h8000_0008, 32'h0000_0002, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h8000_00F8, 32'h0,         1'b1, 32'h0000_0002};
    vecs[12] = '{1'b1, 32'h8000_0008, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h8000_0008, 32'h0,         1'b1, 32'h0};
  end

  initial begin
    logic [31:0] a, d;
    int          sel;
    logic        we;

    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    rst = 1'b1; memwrite = 1'b0; aluout = '0; writedata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    cycle(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0, "rst_cnt");

    // Vector table
    for (int i = 0; i < NV; i++) begin
      cycle(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].chk, vecs[i].exp,
            $sformatf("vec%0d", i));
    end

    // Counter wrap
    cycle(1'b1, 32'h8000_0000, 32'hFFFF_FFFE, 1'b0, 32'h0, "wrap_wr");
    cycle(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'hFFFF_FFFE, "wrap0");
    cycle(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'hFFFF_FFFF, "wrap1");
    cycle(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0000_0000, "wrap2");
    cycle(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0000_0001, "wrap3");

    // Match: flag and irq rise the cycle after CNT reads CMP
    cycle(1'b1, 32'h8000_0004, 32'd100, 1'b0, 32'h0, "m_cmp");
    cycle(1'b1, 32'h8000_0008, 32'h2,   1'b0, 32'h0, "m_ien");
    cycle(1'b1, 32'h8000_0000, 32'd95,  1'b0, 32'h0, "m_cnt");
    for (int k = 95; k < 100; k++)
      cycle(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'(k), $sformatf("m_cnt%0d", k));
    #4;
    check("m_irq_before", 32'(irq), 32'h0);
    cycle(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'd100, "m_cnt100");
    #4;
    check("m_irq_after", 32'(irq), 32'h1);
    cycle(1'b0, 32'h8000_0008, 32'h0, 1'b1, 32'h3, "m_stat");
    cycle(1'b1, 32'h8000_0008, 32'h3, 1'b0, 32'h0, "m_w1c");
    cycle(1'b0, 32'h8000_0008, 32'h0, 1'b1, 32'h2, "m_cleared");
    check("m_irq_cleared", 32'(irq), 32'h0);

    // Set wins over a same-edge W1C
    cycle(1'b1, 32'h8000_0000, 32'd99, 1'b0, 32'h0, "sw_cnt");
    cycle(1'b0, 32'h8000_0008, 32'h0,  1'b1, 32'h2, "sw_pre");
    cycle(1'b1, 32'h8000_0008, 32'h3,  1'b1, 32'h2, "sw_w1c");
    cycle(1'b0, 32'h8000_0008, 32'h0,  1'b1, 32'h3, "sw_kept");
    cycle(1'b1, 32'h8000_0008, 32'h1,  1'b0, 32'h0, "sw_clr");
    cycle(1'b0, 32'h8000_0008, 32'h0,  1'b1, 32'h0, "sw_clr_rd");

    // LED masking, then async reset mid-sequence
    cycle(1'b1, 32'h8000_000C, 32'hFFFF_FFA5, 1'b0, 32'h0, "led_wr");
    cycle(1'b0, 32'h8000_000C, 32'h0, 1'b1, 32'h0000_00A5, "led_rd");
    check("led_pins", 32'(leds), 32'h0000_00A5);
    cycle(1'b1, 32'h8000_0000, 32'd100, 1'b0, 32'h0, "r_cnt");
    cycle(1'b1, 32'h8000_0008, 32'h2,   1'b0, 32'h0, "r_ien");
    #1;
    check("r_irq_armed", 32'(irq), 32'h1);
    memwrite = 1'b1; aluout = 32'h8000_000C; writedata = 32'h77;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("r_async_leds", 32'(leds), 32'h0);
    check("r_async_irq", 32'(irq), 32'h0);
    check("r_async_rd", readdata, 32'h0);
    aluout = 32'h0000_0010; writedata = 32'h5555_5555;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0, "r_cnt0");
    cycle(1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, "r_ram_kept");
    cycle(1'b0, 32'h8000_0004, 32'h0, 1'b1, 32'hFFFF_FFFF, "r_cmp");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 3);
      we  = ($urandom_range(0, 2) == 0);
      d   = $urandom;
      if (sel < 2) begin
        a = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 10)
            | 32'($urandom_range(0, 3));
      end else begin
        a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFF0) | 32'($urandom_range(0, 3));
        a[3:2] = 2'($urandom_range(0, 3));
        if (a[3:2] == 2'd0) d = m_cmp - 32'($urandom_range(0, 4));
        if (a[3:2] == 2'd1) d = m_cnt + 32'($urandom_range(0, 6));
      end
      cycle(we, a, d, 1'b0, 32'h0, $sformatf("rnd%0d", n));
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
